// File: rtl/occupancy_grid.sv
// occupancy_grid: 32x16 signed log-odds map with saturating RMW updates.
// Define OCCUPANCY_CLEAR_EN to compile in the 512-cycle grid clear.
module occupancy_grid #(
  parameter int CELL_WIDTH = 8,
  parameter int FREE_DELTA = 1,
  parameter int OCC_DELTA  = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [4:0]                   x_index,
  input  logic [3:0]                   y_index,
  input  logic                         cell_is_free,
  input  logic                         write_enable,
  output logic                         busy,
  input  logic                         read_enable,
  input  logic [4:0]                   read_x,
  input  logic [3:0]                   read_y,
  output logic signed [CELL_WIDTH-1:0] read_data,
  output logic                         read_valid,
  input  logic                         clear,
  output logic                         clear_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READ   = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
`ifdef OCCUPANCY_CLEAR_EN
  localparam logic [1:0] S_CLEAR  = 2'd3;
`endif

  localparam int MAXI = (1 << (CELL_WIDTH - 1)) - 1;
  localparam logic signed [CELL_WIDTH:0] C_MAX  = (CELL_WIDTH + 1)'(MAXI);
  localparam logic signed [CELL_WIDTH:0] C_MIN  = -C_MAX;
  localparam logic signed [CELL_WIDTH:0] C_FREE = (CELL_WIDTH + 1)'(FREE_DELTA);
  localparam logic signed [CELL_WIDTH:0] C_OCC  = (CELL_WIDTH + 1)'(OCC_DELTA);

  logic signed [CELL_WIDTH-1:0] r_mem [512] = '{default: '0};

  logic [1:0]                   r_state;
  logic                         r_busy;
  logic [8:0]                   r_addr;
  logic                         r_free;
  logic signed [CELL_WIDTH-1:0] r_old;
  logic                         r_rvalid;
  logic signed [CELL_WIDTH-1:0] r_rdata;

  logic signed [CELL_WIDTH:0]   w_ext;
  logic signed [CELL_WIDTH:0]   w_sum;
  logic signed [CELL_WIDTH-1:0] w_new;
  logic                         w_we;
  logic [8:0]                   w_waddr;
  logic signed [CELL_WIDTH-1:0] w_wdata;

`ifdef OCCUPANCY_CLEAR_EN
  logic [8:0] r_cnt;
  logic       r_clear_done;
  assign clear_done = r_clear_done;
`else
  logic w_unused_clear;
  assign w_unused_clear = clear;
  assign clear_done     = 1'b0;
`endif

  // One extra bit keeps the sum exact before clamping to the symmetric range
  always_comb begin
    w_ext = {r_old[CELL_WIDTH-1], r_old};
    w_sum = r_free ? (w_ext - C_FREE) : (w_ext + C_OCC);
    if (w_sum > C_MAX)
      w_new = C_MAX[CELL_WIDTH-1:0];
    else if (w_sum < C_MIN)
      w_new = C_MIN[CELL_WIDTH-1:0];
    else
      w_new = w_sum[CELL_WIDTH-1:0];
  end

  always_comb begin
    w_we    = (r_state == S_UPDATE);
    w_waddr = r_addr;
    w_wdata = w_new;
`ifdef OCCUPANCY_CLEAR_EN
    if (r_state == S_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_cnt;
      w_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset && w_we)
      r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_addr  <= '0;
      r_free  <= 1'b0;
      r_old   <= '0;
`ifdef OCCUPANCY_CLEAR_EN
      r_cnt        <= '0;
      r_clear_done <= 1'b0;
`endif
    end else begin
`ifdef OCCUPANCY_CLEAR_EN
      r_clear_done <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (write_enable) begin
            r_addr  <= {y_index, x_index};
            r_free  <= cell_is_free;
            r_state <= S_READ;
            r_busy  <= 1'b1;
          end
`ifdef OCCUPANCY_CLEAR_EN
          else if (clear) begin
            r_cnt   <= '0;
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
          end
`endif
        end
        S_READ: begin
          r_old   <= r_mem[r_addr];
          r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
`ifdef OCCUPANCY_CLEAR_EN
        S_CLEAR: begin
          r_cnt <= r_cnt + 9'd1;
          if (r_cnt == 9'd511) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_clear_done <= 1'b1;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Independent read port; same-edge write leaves the old value here
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= read_enable;
      if (read_enable)
        r_rdata <= r_mem[{read_y, read_x}];
    end
  end

  assign busy       = r_busy;
  assign read_valid = r_rvalid;
  assign read_data  = r_rdata;

endmodule

// File: tb/tb_occupancy_grid.sv
// tb_occupancy_grid: scoreboard bench for occupancy_grid.
// Read results are checked by a monitor against a queue of expectations.
module tb_occupancy_grid;

  logic              clock;
  logic              reset;
  logic [4:0]        x_index;
  logic [3:0]        y_index;
  logic              cell_is_free;
  logic              write_enable;
  logic              busy;
  logic              read_enable;
  logic [4:0]        read_x;
  logic [3:0]        read_y;
  logic signed [7:0] read_data;
  logic              read_valid;
  logic              clear;
  logic              clear_done;

  occupancy_grid dut (
    .clock        (clock),
    .reset        (reset),
    .x_index      (x_index),
    .y_index      (y_index),
    .cell_is_free (cell_is_free),
    .write_enable (write_enable),
    .busy         (busy),
    .read_enable  (read_enable),
    .read_x       (read_x),
    .read_y       (read_y),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .clear        (clear),
    .clear_done   (clear_done)
  );

  int n_pass  = 0;
  int n_total = 0;
  int model [512];
  int exp_q [$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int upd(input int old, input bit free);
    int n;
    n = free ? old - 1 : old + 3;
    if (n > 127)  n = 127;
    if (n < -127) n = -127;
    return n;
  endfunction

  always @(negedge clock) begin
    if (read_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read_valid", 1, 0);
      end else begin
        check("read_data", int'(read_data), exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 1000) begin
      @(posedge clock); #1;
      w++;
    end
    if (busy) check("wait_idle_timeout", int'(busy), 0);
  endtask

  task automatic do_write(input int x, input int y, input bit free);
    int a;
    wait_idle();
    a = y * 32 + x;
    x_index      = 5'(x);
    y_index      = 4'(y);
    cell_is_free = free;
    write_enable = 1'b1;
    @(posedge clock); #1;
    write_enable = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    @(posedge clock); #1;
    check("busy_in_read", int'(busy), 1);
    @(posedge clock); #1;
    check("busy_after_update", int'(busy), 0);
    model[a] = upd(model[a], free);
  endtask

  task automatic do_read(input int x, input int y);
    read_x      = 5'(x);
    read_y      = 4'(y);
    read_enable = 1'b1;
    exp_q.push_back(model[y * 32 + x]);
    @(posedge clock); #1;
    read_enable = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int oldv;
    int nb;
    int nd;
    for (int i = 0; i < 512; i++) model[i] = 0;
    reset        = 1'b0;
    x_index      = '0;
    y_index      = '0;
    cell_is_free = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    read_x       = '0;
    read_y       = '0;
    clear        = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_read_valid", int'(read_valid), 0);
    check("reset_read_data", int'(read_data), 0);
    check("reset_clear_done", int'(clear_done), 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // basic occupied then free update
    do_write(3, 2, 1'b0);
    do_read(3, 2);
    do_write(3, 2, 1'b1);
    do_read(3, 2);

    // positive saturation
    for (int i = 0; i < 50; i++) do_write(31, 15, 1'b0);
    do_read(31, 15);
    do_write(31, 15, 1'b0);
    do_read(31, 15);

    // negative saturation, never -128
    for (int i = 0; i < 200; i++) begin
      do_write(0, 0, 1'b1);
      if (i >= 120) do_read(0, 0);
    end

    // held request, alternating addresses
    wait_idle();
    write_enable = 1'b1;
    cell_is_free = 1'b0;
    for (int k = 0; k < 6; k++) begin
      x_index = (k % 2 == 0) ? 5'd7 : 5'd8;
      y_index = 4'd1;
      @(posedge clock); #1;
      check("held_accept", int'(busy), 1);
      @(posedge clock); #1;
      check("held_read", int'(busy), 1);
      @(posedge clock); #1;
      check("held_done", int'(busy), 0);
      a = 32 + ((k % 2 == 0) ? 7 : 8);
      model[a] = upd(model[a], 1'b0);
    end
    write_enable = 1'b0;
    @(posedge clock); #1;
    check("held_release_idle", int'(busy), 0);
    do_read(7, 1);
    do_read(8, 1);

    // read on the same edge as the write-back
    do_write(5, 5, 1'b0);
    a = 5 * 32 + 5;
    oldv = model[a];
    x_index      = 5'd5;
    y_index      = 4'd5;
    cell_is_free = 1'b0;
    write_enable = 1'b1;
    @(posedge clock); #1;
    write_enable = 1'b0;
    read_x      = 5'd5;
    read_y      = 4'd5;
    @(posedge clock); #1;
    read_enable = 1'b1;
    exp_q.push_back(oldv);
    @(posedge clock); #1;
    check("same_edge_busy_low", int'(busy), 0);
    model[a] = upd(oldv, 1'b0);
    exp_q.push_back(model[a]);
    @(posedge clock); #1;
    read_enable = 1'b0;

    // write and clear together: write wins, clear dropped
    wait_idle();
    x_index      = 5'd10;
    y_index      = 4'd3;
    cell_is_free = 1'b0;
    write_enable = 1'b1;
    clear        = 1'b1;
    @(posedge clock); #1;
    write_enable = 1'b0;
    clear        = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("wc_busy_done", int'(busy), 0);
    model[3 * 32 + 10] = upd(model[3 * 32 + 10], 1'b0);
    @(posedge clock); #1;
    check("wc_clear_ignored", int'(busy), 0);
    do_read(10, 3);

`ifdef OCCUPANCY_CLEAR_EN
    wait_idle();
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    nb = 0;
    nd = 0;
    for (int i = 0; i < 600; i++) begin
      if (busy) nb++;
      if (clear_done) begin
        nd++;
        check("clear_done_with_busy_low", int'(busy), 0);
      end
      @(posedge clock); #1;
    end
    check("clear_busy_cycles", nb, 512);
    check("clear_done_pulses", nd, 1);
    for (int i = 0; i < 512; i++) model[i] = 0;
`else
    wait_idle();
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    nb = 0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) nb++;
      if (clear_done) nd++;
      @(posedge clock); #1;
    end
    check("noclear_busy_cycles", nb, 0);
    check("noclear_done_pulses", nd, 0);
`endif
    do_read(3, 2);
    do_read(31, 15);
    do_read(0, 0);
    do_read(7, 1);
    do_read(5, 5);

    // reset one cycle after accepting a write
    wait_idle();
    x_index      = 5'd9;
    y_index      = 4'd9;
    cell_is_free = 1'b0;
    write_enable = 1'b1;
    @(posedge clock); #1;
    write_enable = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    check("reset_mid_busy", int'(busy), 0);
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("reset_mid_still_idle", int'(busy), 0);
    do_read(9, 9);

    repeat (3) @(posedge clock);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/occupancy_grid.md
# occupancy_grid

Occupancy map store written by the `bresenham` ray tracer: holds a 32×16 grid of signed log-odds cells and applies one saturating read-modify-write update per `write_enable` request. Its `busy` output drives the tracer's `occupancy_busy` input. An independent read port serves the scan matcher and map readout.

## Interface
Parameters:
- `CELL_WIDTH`, 8: signed log-odds width per cell.
- `FREE_DELTA`, 1: magnitude subtracted when a cell is marked free.
- `OCC_DELTA`, 3: magnitude added when a cell is marked occupied.

Ports:
- `clock` in 1: sole clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low.
- `x_index` in 5: column of the write request.
- `y_index` in 4: row of the write request.
- `cell_is_free` in 1: 1 = free update, 0 = occupied update.
- `write_enable` in 1: update request, sampled only while `busy`=0.
- `busy` out 1: registered; high while an update or clear is in progress.
- `read_enable` in 1: read request.
- `read_x` in 5: column to read.
- `read_y` in 4: row to read.
- `read_data` out `CELL_WIDTH`: signed cell value.
- `read_valid` out 1: `read_data` is valid this cycle.
- `clear` in 1: start a grid clear (see Configuration).
- `clear_done` out 1: one-cycle pulse at the end of a clear.

## Operation
- Address = `{y, x}` (y·32 + x), 512 cells.
- Storage is a simple dual-port RAM: one write/read port for updates and clears, one read-only port.
- Cells initialise to 0 at elaboration. `reset` does not clear RAM contents.
- FSM states:
  - IDLE: `busy`=0. `write_enable`=1 latches the address and `cell_is_free`, then → READ. Otherwise `clear`=1 (macro enabled) → CLEAR.
  - READ: issue the RAM read of the latched address, then → UPDATE.
  - UPDATE: compute the new value and write it back, then → IDLE.
  - CLEAR: write 0 to counter address 0..511, one per cycle. After address 511, → IDLE and pulse `clear_done`.
- `write_enable` and `clear` asserted together in IDLE: the write wins; `clear` is ignored and must be re-asserted.
- Update arithmetic:
  - new = old − `FREE_DELTA` if free, old + `OCC_DELTA` otherwise.
  - Compute in `CELL_WIDTH`+1 bits, then clamp to [−(2^(W−1)−1), +(2^(W−1)−1)]; default range is [−127, +127].
  - The most-negative code is never produced.
- `write_enable` while `busy`=1 is ignored, not queued; the requester holds it until `busy` is low.
- Read port: `read_enable` at edge N gives `read_data`/`read_valid` at edge N+1.
  - One read per cycle, fully pipelined, independent of the FSM.
  - Reading a cell on the same edge it is written returns the old value.
  - `read_valid` is 0 when no read was issued; `read_data` then holds its last value.

## Timing
- Reset values: `busy`=0, `read_valid`=0, `read_data`=0, `clear_done`=0, FSM=IDLE, clear counter=0.
- Update: request accepted at edge E0 → `busy`=1 after E0. The RAM write occurs at E2, `busy`=0 after E2.
- Back-to-back updates: one accepted every 3 cycles.
- Clear: `busy`=1 for 512 cycles. `clear_done` is high for exactly one cycle, coinciding with `busy` falling.
- Reset asserted mid-operation:
  - FSM → IDLE and the in-flight update is abandoned; the cell is written only if the UPDATE edge had already occurred.
  - A clear stops partway; already-cleared cells stay 0 and no `clear_done` pulse is issued.
  - The read pipeline is flushed.

## Configuration
- `OCCUPANCY_CLEAR_EN` defined: the CLEAR state, its 9-bit counter and `clear_done` generation are compiled in.
- `OCCUPANCY_CLEAR_EN` undefined:
  - The `clear` port remains but is ignored.
  - `clear_done` is tied to 0.
  - The FSM has only IDLE/READ/UPDATE.

## Test plan
- After reset, write (x=3, y=2, occupied) → `busy`=1 for 2 cycles; a read of (3, 2) then returns 3. Writing the same cell free returns 2.
- 50 occupied writes to (31, 15) → reads 127 and stays 127. 200 free writes to (0, 0) → reads −127, never −128.
- Hold `write_enable` continuously with alternating addresses → exactly one update per 3 cycles; no request lost or duplicated while the requester holds.
- Read of (5, 5) on the same edge as its UPDATE write → returns the pre-update value. The read on the next cycle returns the new value.
- With `OCCUPANCY_CLEAR_EN`: populate cells, pulse `clear` → `busy`=1 for 512 cycles, `clear_done` pulses once, and all reads return 0. Without the macro: `clear` has no effect.
- Assert `reset` one cycle after accepting a write → `busy`=0 next cycle and the target cell keeps its old value.
